// File: rtl/exec_pkg.sv
// Shared opcode and FSM state encodings for the exec_core_p execution controller.
package exec_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_LDI = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

endpackage

// File: rtl/exec_core_p_regfile.sv
// General register file: two operand read ports, one debug read port, one synchronous write port.
module regfile_p #(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 8,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [ADDR_W-1:0] raddr_d,
   output logic [DATA_W-1:0] rdata_d
);

   logic [DATA_W-1:0] mem_reg [NUM_REGS];

   // Combinational reads so EXEC sees operands in the same cycle it computes.
   assign rdata_a = mem_reg[raddr_a];
   assign rdata_b = mem_reg[raddr_b];
   assign rdata_d = mem_reg[raddr_d];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/exec_core_p.sv
// Register-to-register execution controller: IDLE -> EXEC -> WB per command.
// Optional one-entry command queue enabled by defining EXEC_CMD_QUEUE_EN.
module exec_core_p
   import exec_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 8,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [DATA_W-1:0] cmd_imm,
   output logic              done,
   output logic [DATA_W-1:0] result_out,
   output logic              z_flag,
   output logic              c_flag,
   output logic              busy,
   input  logic [ADDR_W-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata
);

   state_t            state_reg, state_next;
   logic [2:0]        op_reg;
   logic [ADDR_W-1:0] rd_reg, rs1_reg, rs2_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [DATA_W-1:0] res_reg;
   logic              carry_reg;
   logic [DATA_W-1:0] opa, opb;
   logic [DATA_W-1:0] alu_r;
   logic              alu_c;
   logic [DATA_W:0]   sum;
   logic              hs, load_cmd, load_q;

   assign hs   = cmd_valid & cmd_ready;
   assign busy = (state_reg != ST_IDLE);

`ifdef EXEC_CMD_QUEUE_EN
   logic              q_valid_reg;
   logic [2:0]        q_op_reg;
   logic [ADDR_W-1:0] q_rd_reg, q_rs1_reg, q_rs2_reg;
   logic [DATA_W-1:0] q_imm_reg;

   assign cmd_ready = !q_valid_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid_reg <= 1'b0;
         q_op_reg    <= '0;
         q_rd_reg    <= '0;
         q_rs1_reg   <= '0;
         q_rs2_reg   <= '0;
         q_imm_reg   <= '0;
      end else if (hs && busy) begin
         q_valid_reg <= 1'b1;
         q_op_reg    <= cmd_op;
         q_rd_reg    <= cmd_rd;
         q_rs1_reg   <= cmd_rs1;
         q_rs2_reg   <= cmd_rs2;
         q_imm_reg   <= cmd_imm;
      end else if (load_q) begin
         q_valid_reg <= 1'b0;
      end
   end
`else
   assign cmd_ready = (state_reg == ST_IDLE);
`endif

   always_comb begin
      state_next = state_reg;
      done       = 1'b0;
      load_cmd   = 1'b0;
      load_q     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
`ifdef EXEC_CMD_QUEUE_EN
            if (q_valid_reg) begin
               load_q     = 1'b1;
               state_next = ST_EXEC;
            end else
`endif
            if (hs) begin
               load_cmd   = 1'b1;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: state_next = ST_WB;
         ST_WB: begin
            done       = 1'b1;
            state_next = ST_IDLE;
`ifdef EXEC_CMD_QUEUE_EN
            // Chain straight into the queued command; its operands see this WB.
            if (q_valid_reg) begin
               load_q     = 1'b1;
               state_next = ST_EXEC;
            end
`endif
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         op_reg    <= '0;
         rd_reg    <= '0;
         rs1_reg   <= '0;
         rs2_reg   <= '0;
         imm_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (load_cmd) begin
            op_reg  <= cmd_op;
            rd_reg  <= cmd_rd;
            rs1_reg <= cmd_rs1;
            rs2_reg <= cmd_rs2;
            imm_reg <= cmd_imm;
         end
`ifdef EXEC_CMD_QUEUE_EN
         else if (load_q) begin
            op_reg  <= q_op_reg;
            rd_reg  <= q_rd_reg;
            rs1_reg <= q_rs1_reg;
            rs2_reg <= q_rs2_reg;
            imm_reg <= q_imm_reg;
         end
`endif
      end
   end

   regfile_p #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (state_reg == ST_WB),
      .waddr   (rd_reg),
      .wdata   (res_reg),
      .raddr_a (rs1_reg),
      .rdata_a (opa),
      .raddr_b (rs2_reg),
      .rdata_b (opb),
      .raddr_d (dbg_raddr),
      .rdata_d (dbg_rdata)
   );

   assign sum = {1'b0, opa} + {1'b0, opb};

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      case (op_reg)
         OP_ADD: begin alu_r = sum[DATA_W-1:0]; alu_c = sum[DATA_W]; end
         OP_SUB: begin alu_r = opa - opb; alu_c = (opa < opb); end
         OP_AND: alu_r = opa & opb;
         OP_OR:  alu_r = opa | opb;
         OP_XOR: alu_r = opa ^ opb;
         OP_SHL: begin alu_r = {opa[DATA_W-2:0], 1'b0}; alu_c = opa[DATA_W-1]; end
         OP_SHR: begin alu_r = {1'b0, opa[DATA_W-1:1]}; alu_c = opa[0]; end
         default: alu_r = imm_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_reg    <= '0;
         carry_reg  <= 1'b0;
         result_out <= '0;
         z_flag     <= 1'b0;
         c_flag     <= 1'b0;
      end else if (state_reg == ST_EXEC) begin
         res_reg   <= alu_r;
         carry_reg <= alu_c;
      end else if (state_reg == ST_WB) begin
         result_out <= res_reg;
         z_flag     <= (res_reg == '0);
         c_flag     <= carry_reg;
      end
   end

endmodule
